// File: rtl/usart_tx_if.sv
// Byte handshake between the sync_fifo output side and the USART transmitter.
// master = byte source (FIFO), slave = usart_tx.
`timescale 1ns/1ps
interface usart_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/usart_tx.sv
// USART transmitter: pops bytes over a valid/ready handshake and sends 8N1 frames.
// Optional even parity bit between D7 and stop when USART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module usart_tx #(
  parameter int unsigned CLOCKS_PER_BIT = 16
) (
  input  logic        comm_clock,
  input  logic        reset,
  usart_tx_if.slave   bus,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned CntW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef USART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            accept;
  logic            bit_end;
`ifdef USART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  // Combinational so the FIFO can pop in the same cycle it presents data.
  assign accept       = (state_q == StIdle) && !reset;
  assign bus.in_ready = accept;
  assign bit_end      = (cnt_q == '0);
  assign tx           = tx_q;
  assign busy         = busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
`ifdef USART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.in_valid && accept) begin
          state_d = StStart;
          cnt_d   = CntLoad;
          idx_d   = 3'd0;
          shreg_d = bus.in_data;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef USART_TX_PARITY_EN
          parity_d = ^bus.in_data;
`endif
        end
      end

      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = CntLoad;
          idx_d   = 3'd0;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StData: begin
        if (!bit_end) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (idx_q == 3'd7) begin
          cnt_d = CntLoad;
`ifdef USART_TX_PARITY_EN
          state_d = StParity;
          tx_d    = parity_q;
`else
          state_d = StStop;
          tx_d    = 1'b1;
`endif
        end else begin
          // Next bit to drive is shreg_q[1], which becomes bit 0 after the shift.
          cnt_d   = CntLoad;
          idx_d   = idx_q + 3'd1;
          shreg_d = {1'b0, shreg_q[7:1]};
          tx_d    = shreg_q[1];
        end
      end

`ifdef USART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cnt_d   = CntLoad;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`endif

      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge comm_clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef USART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef USART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_usart_tx.sv
// Self-checking bench for usart_tx with a queue-based FIFO source and a frame-level model.
`timescale 1ns/1ps
module tb_usart_tx;
  localparam int unsigned Cpb = 4;
`ifdef USART_TX_PARITY_EN
  localparam int unsigned FrameBits = 11;
`else
  localparam int unsigned FrameBits = 10;
`endif
  localparam int unsigned FrameLen = FrameBits * Cpb;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic busy;

  usart_tx_if bus ();

  usart_tx #(.CLOCKS_PER_BIT(Cpb)) dut (
    .comm_clock (clk),
    .reset      (rst),
    .bus        (bus),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO model standing in for sync_fifo's output side.
  logic [7:0] fifo_q[$];
  logic [7:0] idle_data = 8'h00;
  int         pops = 0;
  logic       xfer = 1'b0;

  bit   exp_tx[$];
  bit   exp_busy[$];
  logic tx_tr[$];
  logic busy_tr[$];
  logic rdy_tr[$];

  task automatic fifo_drive();
    bus.in_valid = (fifo_q.size() != 0);
    bus.in_data  = (fifo_q.size() != 0) ? fifo_q[0] : idle_data;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_drive();
  endtask

  always @(negedge clk) xfer <= bus.in_valid && bus.in_ready;

  initial begin : fifo_pop
    logic take;
    forever begin
      @(posedge clk);
      take = xfer;
      #2;
      if (take === 1'b1 && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        pops++;
        fifo_drive();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n);
    tx_tr.delete();
    busy_tr.delete();
    rdy_tr.delete();
    for (int i = 0; i < n; i++) begin
      tx_tr.push_back(tx);
      busy_tr.push_back(busy);
      rdy_tr.push_back(bus.in_ready);
      step();
    end
  endtask

  // Expected line for one byte: each frame bit held Cpb cycles, then gap idle-high cycles.
  task automatic model_frame(input logic [7:0] b, input int gap);
    int v;
    int ones;
    int bits[$];
    v    = int'(b);
    ones = 0;
    bits.push_back(0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back((v / (1 << i)) % 2);
      ones += (v / (1 << i)) % 2;
    end
`ifdef USART_TX_PARITY_EN
    bits.push_back(ones % 2);
`endif
    bits.push_back(1);
    foreach (bits[k]) begin
      for (int c = 0; c < Cpb; c++) begin
        exp_tx.push_back(bits[k] != 0);
        exp_busy.push_back(1'b1);
      end
    end
    for (int g = 0; g < gap; g++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.in_ready !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: ready=%b tx=%b busy=%b, want ready=0 tx=1 busy=0",
                 i, bus.in_ready, tx, busy);
      end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (bus.in_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_empty cyc%0d: ready=%b tx=%b busy=%b, want ready=1 tx=1 busy=0",
                 i, bus.in_ready, tx, busy);
      end
      step();
    end
  endtask

  task automatic test_single();
    int base;
    int busy_cnt;
    base = pops;
    exp_tx.delete();
    exp_busy.delete();
    push_byte(8'hAA);
    step();
    capture(FrameLen + 2);
    model_frame(8'hAA, 2);
    busy_cnt = 0;
    for (int i = 0; i < FrameLen + 2; i++) begin
      if (busy_tr[i] === 1'b1) busy_cnt++;
      checks++;
      if (tx_tr[i] !== exp_tx[i] || busy_tr[i] !== exp_busy[i] || rdy_tr[i] !== !exp_busy[i]) begin
        errors++;
        $display("FAIL single_aa cyc%0d: tx=%b busy=%b ready=%b, want tx=%b busy=%b ready=%b",
                 i, tx_tr[i], busy_tr[i], rdy_tr[i], exp_tx[i], exp_busy[i], !exp_busy[i]);
      end
    end
    checks++;
    if (busy_cnt != int'(FrameLen)) begin
      errors++;
      $display("FAIL single_busy_len: got %0d cycles, want %0d", busy_cnt, FrameLen);
    end
    checks++;
    if (pops != base + 1) begin
      errors++;
      $display("FAIL single_pops: got %0d, want %0d", pops - base, 1);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom_range(255, 0));
      idle_data = 8'($urandom_range(255, 0));
      fifo_drive();
      for (int g = 0; g < int'($urandom_range(5, 0)); g++) step();
      exp_tx.delete();
      exp_busy.delete();
      push_byte(b);
      step();
      capture(FrameLen + 1);
      model_frame(b, 1);
      for (int i = 0; i < FrameLen + 1; i++) begin
        checks++;
        if (tx_tr[i] !== exp_tx[i] || busy_tr[i] !== exp_busy[i]) begin
          errors++;
          $display("FAIL random_%02h cyc%0d: tx=%b busy=%b, want tx=%b busy=%b",
                   b, i, tx_tr[i], busy_tr[i], exp_tx[i], exp_busy[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int r1;
    logic [7:0] rb[4];
    base = pops;
    exp_tx.delete();
    exp_busy.delete();
    push_byte(8'hAA);
    push_byte(8'hBB);
    step();
    capture(2 * FrameLen + 1 + 6);
    model_frame(8'hAA, 1);
    model_frame(8'hBB, 6);
    for (int i = 0; i < 2 * FrameLen + 7; i++) begin
      checks++;
      if (tx_tr[i] !== exp_tx[i] || busy_tr[i] !== exp_busy[i]) begin
        errors++;
        $display("FAIL b2b_aa_bb cyc%0d: tx=%b busy=%b, want tx=%b busy=%b",
                 i, tx_tr[i], busy_tr[i], exp_tx[i], exp_busy[i]);
      end
    end
    r1 = -1;
    for (int i = 1; i < 2 * FrameLen + 7; i++) begin
      if (r1 < 0 && busy_tr[i] === 1'b1 && busy_tr[i-1] === 1'b0) r1 = i;
    end
    checks++;
    if (r1 != int'(FrameLen) + 1 || tx_tr[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start_gap: second start at %0d (first tx=%b), want %0d (first tx=0)",
               r1, tx_tr[0], FrameLen + 1);
    end
    checks++;
    if (pops != base + 2 || fifo_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_pops: pops=%0d left=%0d, want pops=2 left=0",
               pops - base, fifo_q.size());
    end

    exp_tx.delete();
    exp_busy.delete();
    foreach (rb[k]) begin
      rb[k] = 8'($urandom_range(255, 0));
      push_byte(rb[k]);
    end
    step();
    capture(4 * (FrameLen + 1) + 3);
    foreach (rb[k]) model_frame(rb[k], (k == 3) ? 4 : 1);
    for (int i = 0; i < 4 * (FrameLen + 1) + 3; i++) begin
      checks++;
      if (tx_tr[i] !== exp_tx[i] || busy_tr[i] !== exp_busy[i]) begin
        errors++;
        $display("FAIL b2b_random cyc%0d: tx=%b busy=%b, want tx=%b busy=%b",
                 i, tx_tr[i], busy_tr[i], exp_tx[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = pops;
    push_byte(8'h55);
    step();
    for (int i = 0; i < 13; i++) step();
    rst = 1'b1;
    step();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort: tx=%b busy=%b ready=%b, want tx=1 busy=0 ready=0",
               tx, busy, bus.in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || pops != base + 1) begin
      errors++;
      $display("FAIL midreset_release: ready=%b pops=%0d, want ready=1 pops=1",
               bus.in_ready, pops - base);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet cyc%0d: tx=%b busy=%b, want tx=1 busy=0", i, tx, busy);
      end
    end
    exp_tx.delete();
    exp_busy.delete();
    push_byte(8'h0F);
    step();
    capture(FrameLen + 1);
    model_frame(8'h0F, 1);
    for (int i = 0; i < FrameLen + 1; i++) begin
      checks++;
      if (tx_tr[i] !== exp_tx[i] || busy_tr[i] !== exp_busy[i]) begin
        errors++;
        $display("FAIL midreset_next_0f cyc%0d: tx=%b busy=%b, want tx=%b busy=%b",
                 i, tx_tr[i], busy_tr[i], exp_tx[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_data_change();
    idle_data = 8'hFF;
    exp_tx.delete();
    exp_busy.delete();
    push_byte(8'h3C);
    step();
    capture(FrameLen + 1);
    model_frame(8'h3C, 1);
    for (int i = 0; i < FrameLen + 1; i++) begin
      checks++;
      if (tx_tr[i] !== exp_tx[i] || busy_tr[i] !== exp_busy[i]) begin
        errors++;
        $display("FAIL data_change_3c cyc%0d: tx=%b busy=%b, want tx=%b busy=%b",
                 i, tx_tr[i], busy_tr[i], exp_tx[i], exp_busy[i]);
      end
    end
  endtask

`ifdef USART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] pb[2];
    logic       pexp[2];
    int         bc;
    pb[0] = 8'hAA; pexp[0] = 1'b0;
    pb[1] = 8'h07; pexp[1] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      push_byte(pb[n]);
      step();
      capture(FrameLen + 1);
      bc = 0;
      foreach (busy_tr[i]) if (busy_tr[i] === 1'b1) bc++;
      checks++;
      if (tx_tr[9 * Cpb] !== pexp[n] || tx_tr[10 * Cpb - 1] !== pexp[n] || bc != 44) begin
        errors++;
        $display("FAIL parity_%02h: bit=%b/%b busy_len=%0d, want bit=%b busy_len=44",
                 pb[n], tx_tr[9 * Cpb], tx_tr[10 * Cpb - 1], bc, pexp[n]);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    fifo_drive();
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    test_data_change();
`ifdef USART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
